// File: rtl/gpio_seq_pkg.sv
// Shared constants for the GPIO pattern sequencer: register map,
// CTRL/status bit positions and the FSM state encoding.
package gpio_seq_pkg;

  // Register map of the sequencer's own register port
  localparam logic [3:0] REG_CTRL     = 4'd0;
  localparam logic [3:0] REG_TAB_PTR  = 4'd1;
  localparam logic [3:0] REG_TAB_ADDR = 4'd2;
  localparam logic [3:0] REG_TAB_DATA = 4'd3;
  localparam logic [3:0] REG_TAB_HOLD = 4'd4;
  localparam logic [3:0] REG_LEN      = 4'd5;
  localparam logic [3:0] REG_CUR      = 4'd6;

  // CTRL write bits
  localparam int CTRL_START   = 0;
  localparam int CTRL_STOP    = 1;
  localparam int CTRL_LOOP    = 2;
  localparam int CTRL_CLRDONE = 3;

  // CTRL read bits
  localparam int STAT_BUSY = 0;
  localparam int STAT_LOOP = 1;
  localparam int STAT_DONE = 2;

  // Sequencer states; ADVANCE is a combinational decision, not a state
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/gpio_seq_table.sv
// Step table: DEPTH entries of {GPIO word address, data, hold time}.
// One synchronous write port (host commit), one asynchronous read port
// (current step). Contents are intentionally not reset.
module gpio_seq_table #(
  parameter int DEPTH  = 16,
  parameter int PTR_W  = 4,
  parameter int HOLD_W = 16
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [PTR_W-1:0]  waddr_i,
  input  logic [3:0]        wgaddr_i,
  input  logic [15:0]       wdata_i,
  input  logic [HOLD_W-1:0] whold_i,
  input  logic [PTR_W-1:0]  raddr_i,
  output logic [3:0]        rgaddr_o,
  output logic [15:0]       rdata_o,
  output logic [HOLD_W-1:0] rhold_o
);

  logic [3:0]        gaddr_mem [DEPTH];
  logic [15:0]       data_mem  [DEPTH];
  logic [HOLD_W-1:0] hold_mem  [DEPTH];

  // Commit one full entry on a host write
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      gaddr_mem[waddr_i] <= wgaddr_i;
      data_mem[waddr_i]  <= wdata_i;
      hold_mem[waddr_i]  <= whold_i;
    end
  end

  assign rgaddr_o = gaddr_mem[raddr_i];
  assign rdata_o  = data_mem[raddr_i];
  assign rhold_o  = hold_mem[raddr_i];

endmodule

// File: rtl/gpio_seq.sv
// Timed GPIO pattern sequencer plus CPU pass-through arbiter.
// Handshake: the GPIO port has no back-pressure; a write is a single
// cycle with GEn=GWr=1. A CPU access (PEn=1) owns the GPIO port that
// cycle and a pending sequencer write waits until PEn drops.
module gpio_seq
  import gpio_seq_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int PTR_W  = 4,
  parameter int HOLD_W = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [3:0]  Addr,
  output logic [15:0] DataRd,
  input  logic [15:0] DataWr,
  input  logic        En,
  input  logic        Rd,
  input  logic        Wr,
  input  logic [3:0]  PAddr,
  output logic [15:0] PDataRd,
  input  logic [15:0] PDataWr,
  input  logic        PEn,
  input  logic        PRd,
  input  logic        PWr,
  output logic [3:0]  GAddr,
  input  logic [15:0] GDataRd,
  output logic [15:0] GDataWr,
  output logic        GEn,
  output logic        GRd,
  output logic        GWr
);

  localparam logic [PTR_W:0]   LEN_MAX = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_TOP = PTR_W'(DEPTH - 1);

  // Reads are combinational and not gated by the strobe
  logic unused_rd;
  assign unused_rd = Rd;

  state_e            state_q;
  logic [PTR_W-1:0]  cur_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic              done_q;
  logic              loop_q;
  logic [PTR_W-1:0]  tab_ptr_q;
  logic [3:0]        tab_addr_q;
  logic [15:0]       tab_data_q;
  logic [PTR_W:0]    len_q;

  logic [3:0]        ent_gaddr;
  logic [15:0]       ent_data;
  logic [HOLD_W-1:0] ent_hold;

  logic busy;
  logic ctrl_wr, cfg_wr, start_req, stop_req, clr_done, tab_we;

  assign busy      = (state_q != ST_IDLE);
  assign ctrl_wr   = En && Wr && (Addr == REG_CTRL);
  assign cfg_wr    = En && Wr && !busy;
  assign start_req = ctrl_wr && DataWr[CTRL_START];
  assign stop_req  = ctrl_wr && DataWr[CTRL_STOP];
  assign clr_done  = ctrl_wr && DataWr[CTRL_CLRDONE];
  assign tab_we    = cfg_wr && (Addr == REG_TAB_HOLD);

  gpio_seq_table #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .HOLD_W(HOLD_W)
  ) u_table (
    .clk_i   (Clk),
    .we_i    (tab_we),
    .waddr_i (tab_ptr_q),
    .wgaddr_i(tab_addr_q),
    .wdata_i (tab_data_q),
    .whold_i (DataWr[HOLD_W-1:0]),
    .raddr_i (cur_q),
    .rgaddr_o(ent_gaddr),
    .rdata_o (ent_data),
    .rhold_o (ent_hold)
  );

  // Host-visible configuration: staging regs, table pointer, length, loop
  always_ff @(posedge Clk) begin
    if (Reset) begin
      tab_ptr_q  <= '0;
      tab_addr_q <= '0;
      tab_data_q <= '0;
      len_q      <= '0;
      loop_q     <= 1'b0;
    end else begin
      // Loop is live even while busy; it is only sampled at ADVANCE
      if (ctrl_wr) loop_q <= DataWr[CTRL_LOOP];
      if (cfg_wr) begin
        case (Addr)
          REG_TAB_PTR:  tab_ptr_q  <= DataWr[PTR_W-1:0];
          REG_TAB_ADDR: tab_addr_q <= DataWr[3:0];
          REG_TAB_DATA: tab_data_q <= DataWr;
          REG_TAB_HOLD: tab_ptr_q  <= (tab_ptr_q == PTR_TOP) ? '0 : tab_ptr_q + 1'b1;
          REG_LEN:      len_q      <= (DataWr > 16'(DEPTH)) ? LEN_MAX : DataWr[PTR_W:0];
          default: ;
        endcase
      end
    end
  end

  // ADVANCE decision taken at the end of a step (no cycle of its own)
  state_e           adv_state_d;
  logic [PTR_W-1:0] adv_cur_d;
  logic             adv_finish_d;
  always_comb begin
    adv_state_d  = ST_ISSUE;
    adv_cur_d    = cur_q + 1'b1;
    adv_finish_d = 1'b0;
    if (({1'b0, cur_q} + 1'b1) >= len_q) begin
      if (loop_q) begin
        adv_cur_d = '0;
      end else begin
        adv_state_d  = ST_IDLE;
        adv_cur_d    = cur_q;
        adv_finish_d = 1'b1;
      end
    end
  end

  // Sequencer FSM: IDLE -> ISSUE (deferred while CPU owns the port) -> HOLD
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      cur_q      <= '0;
      hold_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      if (clr_done) done_q <= 1'b0;
      if (stop_req) begin
        // Stop beats Start in the same write; CUR and Done are left alone
        state_q    <= ST_IDLE;
        hold_cnt_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_req && (len_q != '0)) begin
              state_q <= ST_ISSUE;
              cur_q   <= '0;
              done_q  <= 1'b0;
            end
          end
          ST_ISSUE: begin
            if (!PEn) begin
              if (ent_hold != '0) begin
                state_q    <= ST_HOLD;
                hold_cnt_q <= ent_hold;
              end else begin
                state_q <= adv_state_d;
                cur_q   <= adv_cur_d;
                if (adv_finish_d) done_q <= 1'b1;
              end
            end
          end
          ST_HOLD: begin
            if (hold_cnt_q <= HOLD_W'(1)) begin
              hold_cnt_q <= '0;
              state_q    <= adv_state_d;
              cur_q      <= adv_cur_d;
              if (adv_finish_d) done_q <= 1'b1;
            end else begin
              hold_cnt_q <= hold_cnt_q - 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // Register read mux; unmapped addresses and unused bits read 0
  always_comb begin
    DataRd = '0;
    case (Addr)
      REG_CTRL: begin
        DataRd[STAT_BUSY] = busy;
        DataRd[STAT_LOOP] = loop_q;
        DataRd[STAT_DONE] = done_q;
      end
      REG_TAB_PTR:  DataRd[PTR_W-1:0] = tab_ptr_q;
      REG_TAB_ADDR: DataRd[3:0]       = tab_addr_q;
      REG_TAB_DATA: DataRd            = tab_data_q;
      REG_LEN:      DataRd[PTR_W:0]   = len_q;
      REG_CUR:      DataRd[PTR_W-1:0] = cur_q;
      default: ;
    endcase
  end

  // GPIO port arbitration: CPU pass-through has absolute priority
  always_comb begin
    if (PEn) begin
      GEn     = PEn;
      GRd     = PRd;
      GWr     = PWr;
      GAddr   = PAddr;
      GDataWr = PDataWr;
    end else begin
      GEn     = (state_q == ST_ISSUE);
      GRd     = 1'b0;
      GWr     = (state_q == ST_ISSUE);
      GAddr   = (state_q == ST_ISSUE) ? ent_gaddr : 4'd0;
      GDataWr = (state_q == ST_ISSUE) ? ent_data : 16'd0;
    end
  end

  assign PDataRd = GDataRd;

endmodule
